// File: rtl/lookup_ctrl_fa_l2.sv
// Lookup/fill sequencer for the fully associative L2 tag memory; L2_LOOKUP_PLRU_EN selects tree-PLRU, else round-robin.
// Latency: hit result 2 cycles after accept, miss/fill result 3 cycles after accept.
// Backpressure: req_ready_o is high only in IDLE, so one request is outstanding at a time.
`timescale 1ns/1ps
`ifndef BW_WORD_ADDR
`define BW_WORD_ADDR 32
`endif
`ifndef BW_BLOCK
`define BW_BLOCK 6
`endif

module lookup_ctrl_fa_l2 #(
    parameter int CACHE_BLOCK_CAPACITY = 128,
    parameter int BW_CACHE_ADDR        = $clog2(CACHE_BLOCK_CAPACITY),
    parameter int BW_TAG               = `BW_WORD_ADDR - `BW_BLOCK
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     req_i,
    input  logic [BW_TAG-1:0]        req_tag_i,
    output logic                     req_ready_o,
    output logic                     done_o,
    output logic                     done_hit_o,
    output logic [BW_CACHE_ADDR-1:0] done_add_o,
    output logic                     evict_o,
    output logic [BW_TAG-1:0]        evict_tag_o,
    output logic [BW_TAG-1:0]        tm_tag_o,
    output logic [BW_CACHE_ADDR-1:0] tm_add_o,
    output logic                     tm_wren_o,
    output logic                     tm_rmen_o,
    input  logic                     tm_hit_i,
    input  logic [BW_CACHE_ADDR-1:0] tm_add_i,
    input  logic [BW_TAG-1:0]        tm_tag_i
);

    localparam int NW = BW_CACHE_ADDR + 1;
    localparam logic [NW-1:0] CAP_N = NW'(CACHE_BLOCK_CAPACITY);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        RESOLVE = 2'd2,
        FILL    = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [BW_TAG-1:0]        tm_tag_q, tm_tag_d;
    logic [BW_CACHE_ADDR-1:0] tm_add_q, tm_add_d;
    logic                     tm_wren_q, tm_wren_d;
    logic                     evict_q, evict_d;
    logic [BW_CACHE_ADDR-1:0] done_add_q, done_add_d;
    logic [BW_TAG-1:0]        evict_tag_q, evict_tag_d;
    logic [NW-1:0]            fill_cnt_q, fill_cnt_d;
    logic [BW_CACHE_ADDR-1:0] victim;
    logic                     fill_avail;

    assign fill_avail = (fill_cnt_q < CAP_N);

`ifdef L2_LOOKUP_PLRU_EN
    logic [CACHE_BLOCK_CAPACITY-2:0] plru_q, plru_d;
    logic [NW-1:0]                   walk_node, upd_node;
    logic                            walk_bit, upd_dir, upd_en;
    logic [BW_CACHE_ADDR-1:0]        upd_add;

    // Follow the node bits from the root; leaves sit at heap index CAP-1 .. 2*CAP-2.
    always_comb begin
        walk_node = '0;
        walk_bit  = 1'b0;
        for (int l = 0; l < BW_CACHE_ADDR; l++) begin
            walk_bit = 1'b0;
            for (int n = 0; n < CACHE_BLOCK_CAPACITY - 1; n++) begin
                if (walk_node == NW'(n)) walk_bit = plru_q[n];
            end
            walk_node = {walk_node[BW_CACHE_ADDR-1:0], 1'b1} + NW'(walk_bit);
        end
        victim = BW_CACHE_ADDR'(walk_node - NW'(CACHE_BLOCK_CAPACITY - 1));
    end

    always_comb begin
        upd_en   = ((state_q == RESOLVE) && tm_hit_i) || (state_q == FILL);
        upd_add  = (state_q == FILL) ? tm_add_q : tm_add_i;
        plru_d   = plru_q;
        upd_node = '0;
        upd_dir  = 1'b0;
        if (upd_en) begin
            for (int l = 0; l < BW_CACHE_ADDR; l++) begin
                upd_dir = upd_add[BW_CACHE_ADDR-1-l];
                for (int n = 0; n < CACHE_BLOCK_CAPACITY - 1; n++) begin
                    if (upd_node == NW'(n)) plru_d[n] = ~upd_dir;
                end
                upd_node = {upd_node[BW_CACHE_ADDR-1:0], 1'b1} + NW'(upd_dir);
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) plru_q <= '0;
        else         plru_q <= plru_d;
    end
`else
    logic [BW_CACHE_ADDR-1:0] rr_q;

    // Pointer only moves when a valid block is actually replaced.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)                            rr_q <= '0;
        else if ((state_q == FILL) && evict_q) rr_q <= rr_q + BW_CACHE_ADDR'(1);
    end

    assign victim = rr_q;
`endif

    always_comb begin
        state_d     = state_q;
        tm_tag_d    = tm_tag_q;
        tm_add_d    = tm_add_q;
        tm_wren_d   = 1'b0;
        evict_d     = evict_q;
        done_add_d  = done_add_q;
        evict_tag_d = evict_tag_q;
        fill_cnt_d  = fill_cnt_q;
        req_ready_o = 1'b0;
        done_o      = 1'b0;
        done_hit_o  = 1'b0;
        done_add_o  = done_add_q;
        evict_o     = 1'b0;
        evict_tag_o = evict_tag_q;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_i) begin
                    tm_tag_d = req_tag_i;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: state_d = RESOLVE;
            RESOLVE: begin
                if (tm_hit_i) begin
                    done_o     = 1'b1;
                    done_hit_o = 1'b1;
                    done_add_o = tm_add_i;
                    done_add_d = tm_add_i;
                    state_d    = IDLE;
                end else begin
                    // Victim is fixed here so the FILL cycle drives registered address/write.
                    tm_wren_d = 1'b1;
                    state_d   = FILL;
                    if (fill_avail) begin
                        tm_add_d = fill_cnt_q[BW_CACHE_ADDR-1:0];
                        evict_d  = 1'b0;
                    end else begin
                        tm_add_d = victim;
                        evict_d  = 1'b1;
                    end
                end
            end
            FILL: begin
                done_o     = 1'b1;
                done_add_o = tm_add_q;
                done_add_d = tm_add_q;
                evict_o    = evict_q;
                if (evict_q) begin
                    evict_tag_o = tm_tag_i;
                    evict_tag_d = tm_tag_i;
                end else begin
                    fill_cnt_d = fill_cnt_q + NW'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            tm_tag_q    <= '0;
            tm_add_q    <= '0;
            tm_wren_q   <= 1'b0;
            evict_q     <= 1'b0;
            done_add_q  <= '0;
            evict_tag_q <= '0;
            fill_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            tm_tag_q    <= tm_tag_d;
            tm_add_q    <= tm_add_d;
            tm_wren_q   <= tm_wren_d;
            evict_q     <= evict_d;
            done_add_q  <= done_add_d;
            evict_tag_q <= evict_tag_d;
            fill_cnt_q  <= fill_cnt_d;
        end
    end

    assign tm_tag_o  = tm_tag_q;
    assign tm_add_o  = tm_add_q;
    assign tm_wren_o = tm_wren_q;
    assign tm_rmen_o = 1'b0;

endmodule

// File: tb/tb_lookup_ctrl_fa_l2.sv
// Bench for lookup_ctrl_fa_l2 (CAPACITY 4): directed scenarios plus randomized held-request traffic
// against a cache-level reference model; a simple tag memory sits around the DUT.
`timescale 1ns/1ps

module tb_lookup_ctrl_fa_l2;
    localparam int CAP = 4;
    localparam int AW  = 2;
    localparam int TW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_i;
    logic [TW-1:0] req_tag_i;
    logic          req_ready_o, done_o, done_hit_o, evict_o;
    logic [AW-1:0] done_add_o, tm_add_o, tm_add_i;
    logic [TW-1:0] evict_tag_o, tm_tag_o, tm_tag_i;
    logic          tm_wren_o, tm_rmen_o, tm_hit_i;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lookup_ctrl_fa_l2 #(.CACHE_BLOCK_CAPACITY(CAP), .BW_CACHE_ADDR(AW), .BW_TAG(TW)) dut (
        .clock_i(clk), .reset_i(rst), .req_i(req_i), .req_tag_i(req_tag_i),
        .req_ready_o(req_ready_o), .done_o(done_o), .done_hit_o(done_hit_o),
        .done_add_o(done_add_o), .evict_o(evict_o), .evict_tag_o(evict_tag_o),
        .tm_tag_o(tm_tag_o), .tm_add_o(tm_add_o), .tm_wren_o(tm_wren_o), .tm_rmen_o(tm_rmen_o),
        .tm_hit_i(tm_hit_i), .tm_add_i(tm_add_i), .tm_tag_i(tm_tag_i)
    );

    // Tag memory: registered match, combinational read of tm_add_o, write on tm_wren_o.
    logic [TW-1:0] tmem_tag [CAP];
    logic          tmem_vld [CAP];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tm_hit_i <= 1'b0;
            tm_add_i <= '0;
            for (int i = 0; i < CAP; i++) begin
                tmem_tag[i] <= '0;
                tmem_vld[i] <= 1'b0;
            end
        end else begin
            tm_hit_i <= 1'b0;
            tm_add_i <= '0;
            for (int i = 0; i < CAP; i++)
                if (tmem_vld[i] && tmem_tag[i] == tm_tag_o) begin
                    tm_hit_i <= 1'b1;
                    tm_add_i <= AW'(i);
                end
            if (tm_wren_o) begin
                tmem_tag[tm_add_o] <= tm_tag_o;
                tmem_vld[tm_add_o] <= 1'b1;
            end
        end
    end
    assign tm_tag_i = tmem_tag[tm_add_o];

    // Reference cache model: contents, fill count and replacement policy.
    logic [TW-1:0] m_tag [CAP];
    logic          m_vld [CAP];
    int            m_fill;
    int            m_rr;
    int            m_plru [CAP-1];

    task automatic model_reset();
        for (int i = 0; i < CAP; i++) begin m_tag[i] = '0; m_vld[i] = 1'b0; end
        for (int i = 0; i < CAP - 1; i++) m_plru[i] = 0;
        m_fill = 0;
        m_rr   = 0;
    endtask

`ifdef L2_LOOKUP_PLRU_EN
    function automatic int plru_victim();
        int idx = 0;
        for (int l = 0; l < AW; l++) idx = idx * 2 + m_plru[(1 << l) - 1 + idx];
        return idx;
    endfunction

    task automatic plru_touch(input int a);
        for (int l = 0; l < AW; l++)
            m_plru[(1 << l) - 1 + (a >> (AW - l))] = 1 - ((a >> (AW - 1 - l)) & 1);
    endtask
`endif

    task automatic model_access(input logic [TW-1:0] tag, output logic hit, output int add,
                                output logic ev, output logic [TW-1:0] etag);
        hit = 1'b0; add = 0; ev = 1'b0; etag = '0;
        for (int i = 0; i < CAP; i++)
            if (m_vld[i] && m_tag[i] == tag) begin hit = 1'b1; add = i; end
        if (!hit) begin
            if (m_fill < CAP) begin
                add = m_fill;
                m_fill++;
            end else begin
                ev = 1'b1;
`ifdef L2_LOOKUP_PLRU_EN
                add = plru_victim();
`else
                add  = m_rr;
                m_rr = (m_rr + 1) % CAP;
`endif
                etag = m_tag[add];
            end
            m_tag[add] = tag;
            m_vld[add] = 1'b1;
        end
`ifdef L2_LOOKUP_PLRU_EN
        plru_touch(add);
`endif
    endtask

    task automatic apply_reset();
        req_i = 1'b0; req_tag_i = '0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One request from an idle negedge; lat is the negedge index after the accept edge where done_o is seen.
    task automatic do_txn(input logic [TW-1:0] tag, output int lat, output logic hit,
                          output logic [AW-1:0] add, output logic ev, output logic [TW-1:0] etag,
                          output logic wren, output logic [AW-1:0] tadd, output logic [TW-1:0] ttag1,
                          output int busy_rdy, output int wren_cnt);
        lat = -1; hit = 1'b0; add = '0; ev = 1'b0; etag = '0; wren = 1'b0; tadd = '0;
        ttag1 = '0; busy_rdy = 0; wren_cnt = 0;
        req_i = 1'b1; req_tag_i = tag;
        @(posedge clk);
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            @(negedge clk);
            req_i = 1'b0;
            req_tag_i = TW'($urandom);
            if (k == 1) ttag1 = tm_tag_o;
            if (req_ready_o) busy_rdy++;
            if (tm_wren_o) wren_cnt++;
            if (done_o) begin
                lat = k; hit = done_hit_o; add = done_add_o; ev = evict_o; etag = evict_tag_o;
                wren = tm_wren_o; tadd = tm_add_o;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", req_ready_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done_o); end
        n_cmp++; if (done_hit_o !== 1'b0) begin n_err++; $display("FAIL reset_done_hit got=%b want=0", done_hit_o); end
        n_cmp++; if (done_add_o !== '0) begin n_err++; $display("FAIL reset_done_add got=%0d want=0", done_add_o); end
        n_cmp++; if (evict_o !== 1'b0) begin n_err++; $display("FAIL reset_evict got=%b want=0", evict_o); end
        n_cmp++; if (evict_tag_o !== '0) begin n_err++; $display("FAIL reset_evict_tag got=%h want=0", evict_tag_o); end
        n_cmp++; if (tm_tag_o !== '0) begin n_err++; $display("FAIL reset_tm_tag got=%h want=0", tm_tag_o); end
        n_cmp++; if (tm_add_o !== '0) begin n_err++; $display("FAIL reset_tm_add got=%0d want=0", tm_add_o); end
        n_cmp++; if (tm_wren_o !== 1'b0) begin n_err++; $display("FAIL reset_tm_wren got=%b want=0", tm_wren_o); end
        n_cmp++; if (tm_rmen_o !== 1'b0) begin n_err++; $display("FAIL reset_tm_rmen got=%b want=0", tm_rmen_o); end
    endtask

    task automatic test_first_miss();
        int lat, busy, wc; logic hit, ev, wren; logic [AW-1:0] add, tadd; logic [TW-1:0] etag, tt1;
        do_txn(16'h0010, lat, hit, add, ev, etag, wren, tadd, tt1, busy, wc);
        n_cmp++; if (tt1 !== 16'h0010) begin n_err++; $display("FAIL miss_tm_tag got=%h want=0010", tt1); end
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL miss_latency got=%0d want=3", lat); end
        n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL miss_hit got=%b want=0", hit); end
        n_cmp++; if (add !== 2'd0) begin n_err++; $display("FAIL miss_add got=%0d want=0", add); end
        n_cmp++; if (ev !== 1'b0) begin n_err++; $display("FAIL miss_evict got=%b want=0", ev); end
        n_cmp++; if (wren !== 1'b1 || tadd !== 2'd0) begin n_err++; $display("FAIL miss_write got=%b@%0d want=1@0", wren, tadd); end
        n_cmp++; if (busy !== 0 || wc !== 1) begin n_err++; $display("FAIL miss_busy got=rdy%0d/wr%0d want=0/1", busy, wc); end
    endtask

    task automatic test_hit();
        int lat, busy, wc; logic hit, ev, wren; logic [AW-1:0] add, tadd; logic [TW-1:0] etag, tt1;
        do_txn(16'h0010, lat, hit, add, ev, etag, wren, tadd, tt1, busy, wc);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL hit_latency got=%0d want=2", lat); end
        n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL hit_flag got=%b want=1", hit); end
        n_cmp++; if (add !== 2'd0) begin n_err++; $display("FAIL hit_add got=%0d want=0", add); end
        n_cmp++; if (ev !== 1'b0) begin n_err++; $display("FAIL hit_evict got=%b want=0", ev); end
        n_cmp++; if (wc !== 0 || busy !== 0) begin n_err++; $display("FAIL hit_wren got=wr%0d/rdy%0d want=0/0", wc, busy); end
    endtask

    task automatic test_replacement();
        int lat, busy, wc; logic hit, ev, wren; logic [AW-1:0] add, tadd; logic [TW-1:0] etag, tt1;
        logic [TW-1:0] tags [5];
        tags[0] = 16'h00A0; tags[1] = 16'h00B0; tags[2] = 16'h00C0; tags[3] = 16'h00D0; tags[4] = 16'h00E0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            do_txn(tags[i], lat, hit, add, ev, etag, wren, tadd, tt1, busy, wc);
            n_cmp++; if (hit !== 1'b0 || ev !== 1'b0 || add !== AW'(i)) begin n_err++;
                $display("FAIL fill_%0d got=hit%b ev%b add%0d want=hit0 ev0 add%0d", i, hit, ev, add, i); end
        end
        do_txn(tags[0], lat, hit, add, ev, etag, wren, tadd, tt1, busy, wc);
        n_cmp++; if (hit !== 1'b1 || add !== 2'd0) begin n_err++; $display("FAIL repl_hit_a got=hit%b add%0d want=hit1 add0", hit, add); end
        do_txn(tags[4], lat, hit, add, ev, etag, wren, tadd, tt1, busy, wc);
        n_cmp++; if (ev !== 1'b1 || lat !== 3) begin n_err++; $display("FAIL repl_evict got=ev%b lat%0d want=ev1 lat3", ev, lat); end
`ifdef L2_LOOKUP_PLRU_EN
        n_cmp++; if (add !== 2'd2 || etag !== tags[2]) begin n_err++; $display("FAIL repl_victim got=%0d/%h want=2/%h", add, etag, tags[2]); end
`else
        n_cmp++; if (add !== 2'd0 || etag !== tags[0]) begin n_err++; $display("FAIL repl_victim got=%0d/%h want=0/%h", add, etag, tags[0]); end
`endif
    endtask

    task automatic test_reset_mid_fill();
        int lat, busy, wc; logic hit, ev, wren; logic [AW-1:0] add, tadd; logic [TW-1:0] etag, tt1;
        apply_reset();
        req_i = 1'b1; req_tag_i = 16'h0055;
        @(posedge clk);
        @(negedge clk); req_i = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (done_o !== 1'b1 || tm_wren_o !== 1'b1) begin n_err++; $display("FAIL rmf_in_fill got=done%b wren%b want=1/1", done_o, tm_wren_o); end
        rst = 1'b1;
        #1;
        n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL rmf_ready got=%b want=1", req_ready_o); end
        n_cmp++; if (done_o !== 1'b0 || evict_o !== 1'b0) begin n_err++; $display("FAIL rmf_done got=%b/%b want=0/0", done_o, evict_o); end
        n_cmp++; if (tm_wren_o !== 1'b0 || tm_tag_o !== '0) begin n_err++; $display("FAIL rmf_tm got=wren%b tag%h want=0/0", tm_wren_o, tm_tag_o); end
        @(negedge clk); rst = 1'b0; model_reset();
        @(negedge clk);
        do_txn(16'h0055, lat, hit, add, ev, etag, wren, tadd, tt1, busy, wc);
        n_cmp++; if (hit !== 1'b0 || add !== 2'd0 || ev !== 1'b0) begin n_err++;
            $display("FAIL rmf_refill got=hit%b add%0d ev%b want=0/0/0", hit, add, ev); end
    endtask

    task automatic test_saturation();
        int lat, busy, wc; logic hit, ev, wren; logic [AW-1:0] add, tadd; logic [TW-1:0] etag, tt1;
        logic e_hit, e_ev; int e_add; logic [TW-1:0] e_etag;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            model_access(16'h0200 + 16'(i), e_hit, e_add, e_ev, e_etag);
            do_txn(16'h0200 + 16'(i), lat, hit, add, ev, etag, wren, tadd, tt1, busy, wc);
            n_cmp++; if (hit !== e_hit || add !== AW'(e_add) || ev !== e_ev || (e_ev && etag !== e_etag)) begin n_err++;
                $display("FAIL sat_%0d got=hit%b add%0d ev%b tag%h want=hit%b add%0d ev%b tag%h",
                         i, hit, add, ev, etag, e_hit, e_add, e_ev, e_etag); end
            n_cmp++; if (ev !== (i >= 4)) begin n_err++; $display("FAIL sat_evict_%0d got=%b want=%b", i, ev, i >= 4); end
`ifndef L2_LOOKUP_PLRU_EN
            if (i == 4 || i == 5) begin
                n_cmp++; if (add !== AW'(i - 4) || etag !== 16'h0200 + 16'(i - 4)) begin n_err++;
                    $display("FAIL sat_rr_%0d got=%0d/%h want=%0d/%h", i, add, etag, i - 4, 16'h0200 + 16'(i - 4)); end
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        int c, acc_c, accepts, dones, e_add;
        logic busy, e_hit, e_ev; logic [TW-1:0] e_etag;
        apply_reset();
        c = 0; acc_c = 0; accepts = 0; dones = 0; busy = 1'b0;
        e_hit = 1'b0; e_ev = 1'b0; e_add = 0; e_etag = '0;
        req_i = 1'b1;
        while (c < 600 && (c < 400 || busy)) begin
            if (done_o) begin
                n_cmp++;
                if (!busy) begin n_err++; $display("FAIL b2b_spurious_done cycle=%0d got=1 want=0", c); end
                else if (done_hit_o !== e_hit || done_add_o !== AW'(e_add) || evict_o !== e_ev ||
                         (e_ev && evict_tag_o !== e_etag) || (c - acc_c) !== (e_hit ? 2 : 3)) begin
                    n_err++;
                    $display("FAIL b2b_result cycle=%0d got=hit%b add%0d ev%b tag%h lat%0d want=hit%b add%0d ev%b tag%h lat%0d",
                             c, done_hit_o, done_add_o, evict_o, evict_tag_o, c - acc_c,
                             e_hit, e_add, e_ev, e_etag, e_hit ? 2 : 3);
                end
                busy = 1'b0;
                dones++;
            end else begin
                n_cmp++; if (done_hit_o !== 1'b0 || evict_o !== 1'b0) begin n_err++;
                    $display("FAIL b2b_idle_flags cycle=%0d got=%b/%b want=0/0", c, done_hit_o, evict_o); end
            end
            n_cmp++; if (tm_wren_o !== (done_o && !done_hit_o)) begin n_err++;
                $display("FAIL b2b_wren cycle=%0d got=%b want=%b", c, tm_wren_o, done_o && !done_hit_o); end
            n_cmp++; if (busy && req_ready_o) begin n_err++; $display("FAIL b2b_ready_busy cycle=%0d got=1 want=0", c); end
            if (c < 400) req_tag_i = 16'h0300 + 16'($urandom_range(0, 6));
            else         req_i = 1'b0;
            if (req_i && req_ready_o) begin
                model_access(req_tag_i, e_hit, e_add, e_ev, e_etag);
                busy = 1'b1; acc_c = c; accepts++;
            end
            @(negedge clk);
            c++;
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_timeout got=busy want=idle"); end
        n_cmp++; if (dones !== accepts || accepts < 50) begin n_err++;
            $display("FAIL b2b_count got=%0d done want=%0d accepts (>=50)", dones, accepts); end
    endtask

    initial begin
        rst = 1'b1; req_i = 1'b0; req_tag_i = '0;
        model_reset();
        test_reset();
        test_first_miss();
        test_hit();
        test_replacement();
        test_reset_mid_fill();
        test_saturation();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lookup_ctrl_fa_l2.md
Name: lookup_ctrl_fa_L2

Overview:
- Sequencer directly upstream of the fully associative L2 tag memory. It accepts one tag lookup request at a time and drives the tag memory's tag, address, write and remove inputs.
- It waits out the tag memory's one-cycle registered hit latency, then resolves the result.
- On a miss it allocates a free block or selects a replacement victim, then writes the new tag.
- It reports hit/miss, the cache block address, and any evicted tag to the L2 controller.

Parameters:
- CACHE_BLOCK_CAPACITY, 128, number of blocks; must be a power of 2 and at least 2.
- BW_CACHE_ADDR, `CLOG2(CACHE_BLOCK_CAPACITY), block address width.
- BW_TAG, `BW_WORD_ADDR - `BW_BLOCK, tag width.

Ports:
- clock_i  in  1  single clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- req_i  in  1  lookup request valid.
- req_tag_i  in  BW_TAG  tag to look up.
- req_ready_o  out  1  high only in IDLE; a request is accepted when req_i && req_ready_o.
- done_o  out  1  single-cycle pulse; result valid.
- done_hit_o  out  1  1 = hit, 0 = miss (filled).
- done_add_o  out  BW_CACHE_ADDR  block address that was hit or filled.
- evict_o  out  1  with done_o: a valid block was replaced.
- evict_tag_o  out  BW_TAG  tag of the replaced block.
- tm_tag_o  out  BW_TAG  to tag memory tag_i.
- tm_add_o  out  BW_CACHE_ADDR  to tag memory add_i.
- tm_wren_o  out  1  to tag memory wren_i.
- tm_rmen_o  out  1  to tag memory rmen_i; held 0 by this block.
- tm_hit_i  in  1  from tag memory hit_o; registered, valid one cycle after the tag is presented.
- tm_add_i  in  BW_CACHE_ADDR  from tag memory add_o.
- tm_tag_i  in  BW_TAG  from tag memory tag_o; combinational read of tm_add_o.

Behaviour:
- Clock and reset: one clock, clock_i. Reset is asynchronous and active-high on reset_i.
- Reset values:
  - State = IDLE; req_ready_o = 1.
  - All other outputs = 0, including tm_tag_o and tm_add_o.
  - Fill counter = 0; replacement state cleared (all PLRU bits 0, or RR pointer 0).
- State machine:
  - IDLE: req_ready_o = 1. On accept, register req_tag_i into tm_tag_o and go to LOOKUP. req_i is ignored in every other state.
  - LOOKUP (1 cycle): tm_tag_o holds the tag while the tag memory registers its match. Go to RESOLVE.
  - RESOLVE (1 cycle): sample tm_hit_i and tm_add_i.
    - Hit: done_o = 1, done_hit_o = 1, done_add_o = tm_add_i; update replacement state with tm_add_i; go to IDLE.
    - Miss: go to FILL.
  - FILL (1 cycle): victim V is chosen.
    - Fill counter < CAPACITY: V = fill counter; evict_o = 0; counter increments.
    - Otherwise: V = replacement choice; evict_o = 1; evict_tag_o = tm_tag_i (old tag read combinationally before the write edge).
    - Drive tm_add_o = V and tm_wren_o = 1.
    - done_o = 1, done_hit_o = 0, done_add_o = V.
    - Update replacement state with V; go to IDLE.
- Latency, with the accept edge at cycle 0:
  - Hit: done_o in cycle 2; next accept possible in cycle 3.
  - Miss: done_o in cycle 3; next accept possible in cycle 4.
- Output timing:
  - tm_wren_o is high only in FILL.
  - done_* and evict_* are valid only while done_o = 1. Otherwise done_hit_o and evict_o = 0; done_add_o and evict_tag_o hold their last values.
- Fill counter: width BW_CACHE_ADDR+1; saturates at CAPACITY and never wraps.
- Reset mid-operation: immediately return to IDLE and clear the counter and replacement state. No tm_wren_o is issued. The tag memory is reset by the same system reset.
- tm_tag_o holds the last accepted tag while in IDLE.

Optional Feature:
- Macro: L2_LOOKUP_PLRU_EN.
- Defined: tree-PLRU with CAPACITY-1 bits.
  - Node 0 is the root; node n has children 2n+1 and 2n+2.
  - Bit 0 means the victim is in the left subtree; bit 1 means the right subtree.
  - On an update with index a, every node on a's path is set to point away from a.
  - The victim is found by following the bits from the root.
- Undefined: round-robin pointer of width BW_CACHE_ADDR, reset 0.
  - The victim is the pointer value.
  - The pointer increments, with wrap, only on a FILL with evict_o = 1.
  - Hits do not change it.

Test Plan (CAPACITY = 4):
1. Reset, then a request with tag 0x10 at cycle 0 -> cycle 1 tm_tag_o = 0x10; cycle 3 done_o = 1, done_hit_o = 0, done_add_o = 0, evict_o = 0, tm_wren_o = 1 with tm_add_o = 0.
2. After 1, request tag 0x10 again -> done_o in cycle 2, done_hit_o = 1, done_add_o = 0, tm_wren_o stays 0.
3. Fill tags A, B, C, D (blocks 0-3), hit A, then miss E -> with PLRU: done_add_o = 2, evict_o = 1, evict_tag_o = C. Without PLRU: done_add_o = 0, evict_tag_o = A.
4. Hold req_i high continuously -> exactly one accept per transaction; req_ready_o low in LOOKUP, RESOLVE and FILL; no lost or duplicated done_o pulses.
5. Assert reset_i during FILL of the first miss -> outputs clear asynchronously, req_ready_o = 1. The next miss fills block 0 with evict_o = 0.
6. Five distinct misses, then a sixth, without PLRU -> the fifth and sixth miss evict blocks 0 and 1 in order; fill counter stays saturated at 4.
